// File: rtl/sens_status_arb_pkg.sv
// Shared definitions for the sensor-channel status arbiters: state encoding,
// index-width helper and the default status packet length.
package sens_status_arb_pkg;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_OFFER_ENC = 2'd1;
   localparam logic [1:0] ST_XFER_ENC  = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_OFFER = ST_OFFER_ENC,
      ST_XFER  = ST_XFER_ENC
   } arb_state_t;

   localparam int STATUS_PKT_BYTES = 5;

   // Width of a source index; never below one bit so a 1-source build still elaborates.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sens_status_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, modulo NUM_SRC.
// Returns a one-hot grant (all zero when nothing requests) and the granted index.
module sens_status_rr_pick
   import sens_status_arb_pkg::*;
#(
   parameter int NUM_SRC = 4,
   parameter int IDX_W   = idx_width(NUM_SRC)
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_SRC-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic             found;
   logic [IDX_W-1:0] pos;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int off = 0; off < NUM_SRC; off++) begin
         pos = IDX_W'((int'(ptr) + off) % NUM_SRC);
         if (!found && req[pos]) begin
            found      = 1'b1;
            grant[pos] = 1'b1;
            idx        = pos;
         end
      end
   end

endmodule

// File: rtl/sens_status_arb.sv
// Round-robin arbiter forwarding whole status packets from NUM_SRC sources onto one
// byte-serial status channel. Define SENS_STATUS_ARB_PRIO_EN to give source 0 fixed priority.
module sens_status_arb
   import sens_status_arb_pkg::*;
#(
   parameter int NUM_SRC   = 4,
   parameter int PKT_BYTES = STATUS_PKT_BYTES
) (
   input  logic                   mclk,
   input  logic                   rst,
   input  logic [8*NUM_SRC-1:0]   src_ad,
   input  logic [NUM_SRC-1:0]     src_rq,
   output logic [NUM_SRC-1:0]     src_start,
   output logic [7:0]             status_ad,
   output logic                   status_rq,
   input  logic                   status_start
);

   localparam int IDX_W = idx_width(NUM_SRC);
   localparam int CNT_W = $clog2(PKT_BYTES + 1);

   arb_state_t       state, state_nxt;
   logic [IDX_W-1:0] sel, sel_nxt;
   logic [IDX_W-1:0] rr_ptr, rr_ptr_nxt;
   logic [IDX_W-1:0] sel_inc;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic [NUM_SRC-1:0] pick_req, pick_grant;
   logic [IDX_W-1:0]   pick_idx;
   logic [7:0]         src_byte [NUM_SRC];

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_src_byte
      assign src_byte[i] = src_ad[8*i +: 8];
   end

   // With priority enabled a pending source-0 request hides all others from the picker.
`ifdef SENS_STATUS_ARB_PRIO_EN
   assign pick_req = src_rq[0] ? NUM_SRC'(1) : src_rq;
`else
   assign pick_req = src_rq;
`endif

   sens_status_rr_pick #(
      .NUM_SRC (NUM_SRC),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req   (pick_req),
      .ptr   (rr_ptr),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign sel_inc = (sel == IDX_W'(NUM_SRC - 1)) ? '0 : sel + 1'b1;

   always_ff @(posedge mclk) begin
      if (rst) begin
         state  <= ST_IDLE;
         sel    <= '0;
         rr_ptr <= '0;
         cnt    <= '0;
      end else begin
         state  <= state_nxt;
         sel    <= sel_nxt;
         rr_ptr <= rr_ptr_nxt;
         cnt    <= cnt_nxt;
      end
   end

   // Start is forwarded only while offering, so a packet is never interleaved or restarted.
   always_comb begin
      state_nxt  = state;
      sel_nxt    = sel;
      rr_ptr_nxt = rr_ptr;
      cnt_nxt    = cnt;
      status_rq  = 1'b0;
      status_ad  = 8'h00;
      src_start  = '0;
      case (state)
         ST_IDLE: begin
            if (|pick_grant) begin
               sel_nxt   = pick_idx;
               state_nxt = ST_OFFER;
            end
         end
         ST_OFFER: begin
            status_rq = src_rq[sel];
            status_ad = src_byte[sel];
            if (status_start) begin
               src_start[sel] = 1'b1;
               cnt_nxt        = CNT_W'(PKT_BYTES - 1);
               state_nxt      = ST_XFER;
            end else if (!src_rq[sel]) begin
               state_nxt = ST_IDLE;
            end
         end
         ST_XFER: begin
            status_ad = src_byte[sel];
            cnt_nxt   = cnt - 1'b1;
            if (cnt == CNT_W'(1)) begin
               state_nxt = ST_IDLE;
`ifdef SENS_STATUS_ARB_PRIO_EN
               if (sel != '0) begin
                  rr_ptr_nxt = sel_inc;
               end
`else
               rr_ptr_nxt = sel_inc;
`endif
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sens_status_arb.sv
// Directed testbench for sens_status_arb (NUM_SRC=4, PKT_BYTES=5); the bench plays all
// sources and the downstream sink. Runs the priority scenario when SENS_STATUS_ARB_PRIO_EN is defined.
module tb_sens_status_arb;

   logic        mclk;
   logic        rst;
   logic [31:0] src_ad;
   logic [3:0]  src_rq;
   logic [3:0]  src_start;
   logic [7:0]  status_ad;
   logic        status_rq;
   logic        status_start;
   logic [7:0]  sad [4];

   int vectors;
   int miscompares;

   assign src_ad = {sad[3], sad[2], sad[1], sad[0]};

   sens_status_arb #(
      .NUM_SRC   (4),
      .PKT_BYTES (5)
   ) dut (
      .mclk         (mclk),
      .rst          (rst),
      .src_ad       (src_ad),
      .src_rq       (src_rq),
      .src_start    (src_start),
      .status_ad    (status_ad),
      .status_rq    (status_rq),
      .status_start (status_start)
   );

   always #5 mclk = ~mclk;

   // Byte k of a packet from source i; unique per (i,k), address byte is k=0.
   function automatic logic [7:0] pkt_byte(input logic [1:0] i, input logic [2:0] k);
      return {2'b01, i, 1'b0, k};
   endfunction

   task automatic clear_sources();
      src_rq = 4'b0000;
      for (int i = 0; i < 4; i++) sad[i] = 8'h00;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      status_start = 1'b0;
      @(negedge mclk);
      @(negedge mclk);
      src_rq = 4'hF;
      for (int i = 0; i < 4; i++) sad[i] = 8'hFF;
      #1;
      vectors++;
      if (status_rq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL reset_rq: got %b expected 0", status_rq);
      end
      vectors++;
      if (status_ad !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL reset_ad: got %h expected 00", status_ad);
      end
      vectors++;
      if (src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_start: got %b expected 0000", src_start);
      end
      @(negedge mclk);
      rst = 1'b0;
      clear_sources();
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00 || src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL reset_release: got rq=%b ad=%h start=%b expected 0/00/0000",
                  status_rq, status_ad, src_start);
      end
   endtask

   task automatic test_single_source();
      logic [7:0] bytes [5] = '{8'h31, 8'hA0, 8'h01, 8'h02, 8'h03};
      @(negedge mclk);
      src_rq = 4'b0100;
      sad[2] = bytes[0];
      status_start = 1'b0;
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL single_idle: got rq=%b ad=%h expected 0/00", status_rq, status_ad);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge mclk);
         status_start = (c == 3);
         #1;
         vectors++;
         if (status_rq !== 1'b1 || status_ad !== bytes[0]) begin
            miscompares++;
            $display("[TB] FAIL single_offer c=%0d: got rq=%b ad=%h expected 1/%h",
                     c, status_rq, status_ad, bytes[0]);
         end
         vectors++;
         if (src_start !== ((c == 3) ? 4'b0100 : 4'b0000)) begin
            miscompares++;
            $display("[TB] FAIL single_start c=%0d: got %b expected %b",
                     c, src_start, (c == 3) ? 4'b0100 : 4'b0000);
         end
      end
      for (int k = 1; k < 5; k++) begin
         @(negedge mclk);
         status_start = 1'b0;
         src_rq[2] = 1'b0;
         sad[2] = bytes[k];
         #1;
         vectors++;
         if (status_ad !== bytes[k] || status_rq !== 1'b0 || src_start !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL single_byte k=%0d: got ad=%h rq=%b start=%b expected %h/0/0000",
                     k, status_ad, status_rq, src_start, bytes[k]);
         end
      end
      // rr_ptr should now be 3: with sources 1 and 3 requesting, 3 wins
      @(negedge mclk);
      clear_sources();
      src_rq = 4'b1010;
      sad[1] = 8'h11;
      sad[3] = 8'h33;
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL single_gap: got rq=%b ad=%h expected 0/00", status_rq, status_ad);
      end
      @(negedge mclk);
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== 8'h33) begin
         miscompares++;
         $display("[TB] FAIL single_rr_ptr: got rq=%b ad=%h expected 1/33", status_rq, status_ad);
      end
      @(negedge mclk);
      clear_sources();
      #1;
      vectors++;
      if (status_rq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL single_withdraw: got rq=%b expected 0", status_rq);
      end
   endtask

   task automatic test_all_four();
      logic [1:0] exp;
      @(negedge mclk);
      rst = 1'b1;
      clear_sources();
      status_start = 1'b0;
      @(negedge mclk);
      rst = 1'b0;
      for (int g = 0; g < 5; g++) begin
         exp = 2'(g % 4);
         @(negedge mclk);
         status_start = 1'b0;
         src_rq = 4'hF;
         for (int i = 0; i < 4; i++) sad[i] = pkt_byte(2'(i), 3'd0);
         #1;
         vectors++;
         if (status_rq !== 1'b0 || status_ad !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL rr_gap g=%0d: got rq=%b ad=%h expected 0/00", g, status_rq, status_ad);
         end
         @(negedge mclk);
         status_start = 1'b1;
         #1;
         vectors++;
         if (status_rq !== 1'b1 || status_ad !== pkt_byte(exp, 3'd0)) begin
            miscompares++;
            $display("[TB] FAIL rr_grant g=%0d: got rq=%b ad=%h expected 1/%h",
                     g, status_rq, status_ad, pkt_byte(exp, 3'd0));
         end
         vectors++;
         if (src_start !== (4'b0001 << exp)) begin
            miscompares++;
            $display("[TB] FAIL rr_start g=%0d: got %b expected %b", g, src_start, 4'b0001 << exp);
         end
         for (int k = 1; k < 5; k++) begin
            @(negedge mclk);
            status_start = 1'b0;
            src_rq[exp] = 1'b0;
            sad[exp] = pkt_byte(exp, 3'(k));
            #1;
            vectors++;
            if (status_ad !== pkt_byte(exp, 3'(k)) || status_rq !== 1'b0 || src_start !== 4'b0000) begin
               miscompares++;
               $display("[TB] FAIL rr_byte g=%0d k=%0d: got ad=%h rq=%b start=%b expected %h/0/0000",
                        g, k, status_ad, status_rq, src_start, pkt_byte(exp, 3'(k)));
            end
         end
      end
   endtask

   task automatic test_withdraw();
      @(negedge mclk);
      clear_sources();
      src_rq = 4'b0010;
      sad[1] = pkt_byte(2'd1, 3'd0);
      status_start = 1'b0;
      #1;
      vectors++;
      if (status_rq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL wd_idle: got rq=%b expected 0", status_rq);
      end
      @(negedge mclk);
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== pkt_byte(2'd1, 3'd0)) begin
         miscompares++;
         $display("[TB] FAIL wd_offer: got rq=%b ad=%h expected 1/%h",
                  status_rq, status_ad, pkt_byte(2'd1, 3'd0));
      end
      @(negedge mclk);
      src_rq[1] = 1'b0;
      #1;
      vectors++;
      if (status_rq !== 1'b0 || src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL wd_drop: got rq=%b start=%b expected 0/0000", status_rq, src_start);
      end
      @(negedge mclk);
      src_rq = 4'b0011;
      sad[0] = pkt_byte(2'd0, 3'd0);
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00 || src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL wd_back_idle: got rq=%b ad=%h start=%b expected 0/00/0000",
                  status_rq, status_ad, src_start);
      end
      // rr_ptr still 1, so source 1 beats source 0
      @(negedge mclk);
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== pkt_byte(2'd1, 3'd0)) begin
         miscompares++;
         $display("[TB] FAIL wd_rr_kept: got rq=%b ad=%h expected 1/%h",
                  status_rq, status_ad, pkt_byte(2'd1, 3'd0));
      end
   endtask

   task automatic test_spurious_start();
      @(negedge mclk);
      status_start = 1'b1;
      #1;
      vectors++;
      if (src_start !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL sp_grant: got %b expected 0010", src_start);
      end
      for (int k = 1; k < 5; k++) begin
         @(negedge mclk);
         src_rq[1] = 1'b0;
         sad[1] = pkt_byte(2'd1, 3'(k));
         status_start = (k % 2 == 0);
         #1;
         vectors++;
         if (status_ad !== pkt_byte(2'd1, 3'(k)) || status_rq !== 1'b0 || src_start !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL sp_xfer k=%0d: got ad=%h rq=%b start=%b expected %h/0/0000",
                     k, status_ad, status_rq, src_start, pkt_byte(2'd1, 3'(k)));
         end
      end
      @(negedge mclk);
      status_start = 1'b1;
      sad[1] = 8'h00;
      #1;
      vectors++;
      if (src_start !== 4'b0000 || status_rq !== 1'b0 || status_ad !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL sp_idle: got start=%b rq=%b ad=%h expected 0000/0/00",
                  src_start, status_rq, status_ad);
      end
      @(negedge mclk);
      status_start = 1'b0;
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== pkt_byte(2'd0, 3'd0) || src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL sp_next_offer: got rq=%b ad=%h start=%b expected 1/%h/0000",
                  status_rq, status_ad, src_start, pkt_byte(2'd0, 3'd0));
      end
   endtask

   task automatic test_reset_mid();
      @(negedge mclk);
      status_start = 1'b1;
      #1;
      vectors++;
      if (src_start !== 4'b0001) begin
         miscompares++;
         $display("[TB] FAIL rm_grant: got %b expected 0001", src_start);
      end
      for (int k = 1; k < 4; k++) begin
         @(negedge mclk);
         status_start = 1'b0;
         src_rq[0] = 1'b0;
         sad[0] = pkt_byte(2'd0, 3'(k));
         rst = (k == 3);
         #1;
         vectors++;
         if (status_ad !== pkt_byte(2'd0, 3'(k))) begin
            miscompares++;
            $display("[TB] FAIL rm_byte k=%0d: got %h expected %h", k, status_ad, pkt_byte(2'd0, 3'(k)));
         end
      end
      @(negedge mclk);
      rst = 1'b0;
      clear_sources();
      src_rq = 4'b0010;
      sad[1] = pkt_byte(2'd1, 3'd0);
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00 || src_start !== 4'b0000) begin
         miscompares++;
         $display("[TB] FAIL rm_after_reset: got rq=%b ad=%h start=%b expected 0/00/0000",
                  status_rq, status_ad, src_start);
      end
      @(negedge mclk);
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== pkt_byte(2'd1, 3'd0)) begin
         miscompares++;
         $display("[TB] FAIL rm_regrant: got rq=%b ad=%h expected 1/%h",
                  status_rq, status_ad, pkt_byte(2'd1, 3'd0));
      end
      // Start arriving together with the request withdrawal still transfers the packet
      @(negedge mclk);
      src_rq[1] = 1'b0;
      status_start = 1'b1;
      #1;
      vectors++;
      if (src_start !== 4'b0010) begin
         miscompares++;
         $display("[TB] FAIL rm_start_wins: got %b expected 0010", src_start);
      end
      for (int k = 1; k < 5; k++) begin
         @(negedge mclk);
         status_start = 1'b0;
         sad[1] = pkt_byte(2'd1, 3'(k));
         #1;
         vectors++;
         if (status_ad !== pkt_byte(2'd1, 3'(k)) || status_rq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rm_xfer k=%0d: got ad=%h rq=%b expected %h/0",
                     k, status_ad, status_rq, pkt_byte(2'd1, 3'(k)));
         end
      end
      @(negedge mclk);
      clear_sources();
      #1;
      vectors++;
      if (status_rq !== 1'b0 || status_ad !== 8'h00) begin
         miscompares++;
         $display("[TB] FAIL rm_end_idle: got rq=%b ad=%h expected 0/00", status_rq, status_ad);
      end
   endtask

`ifdef SENS_STATUS_ARB_PRIO_EN
   task automatic test_prio();
      @(negedge mclk);
      rst = 1'b1;
      clear_sources();
      status_start = 1'b0;
      @(negedge mclk);
      rst = 1'b0;
      for (int g = 0; g < 3; g++) begin
         @(negedge mclk);
         src_rq = 4'b1001;
         sad[0] = pkt_byte(2'd0, 3'd0);
         sad[3] = pkt_byte(2'd3, 3'd0);
         status_start = 1'b0;
         #1;
         vectors++;
         if (status_rq !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL prio_gap g=%0d: got rq=%b expected 0", g, status_rq);
         end
         @(negedge mclk);
         status_start = 1'b1;
         #1;
         vectors++;
         if (status_ad !== pkt_byte(2'd0, 3'd0) || src_start !== 4'b0001) begin
            miscompares++;
            $display("[TB] FAIL prio_grant g=%0d: got ad=%h start=%b expected %h/0001",
                     g, status_ad, src_start, pkt_byte(2'd0, 3'd0));
         end
         for (int k = 1; k < 5; k++) begin
            @(negedge mclk);
            status_start = 1'b0;
            src_rq[0] = 1'b0;
            sad[0] = pkt_byte(2'd0, 3'(k));
            #1;
            vectors++;
            if (status_ad !== pkt_byte(2'd0, 3'(k))) begin
               miscompares++;
               $display("[TB] FAIL prio_byte g=%0d k=%0d: got %h expected %h",
                        g, k, status_ad, pkt_byte(2'd0, 3'(k)));
            end
         end
      end
      @(negedge mclk);
      src_rq = 4'b1000;
      sad[0] = 8'h00;
      #1;
      vectors++;
      if (status_rq !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL prio_idle: got rq=%b expected 0", status_rq);
      end
      @(negedge mclk);
      #1;
      vectors++;
      if (status_rq !== 1'b1 || status_ad !== pkt_byte(2'd3, 3'd0)) begin
         miscompares++;
         $display("[TB] FAIL prio_src3: got rq=%b ad=%h expected 1/%h",
                  status_rq, status_ad, pkt_byte(2'd3, 3'd0));
      end
   endtask
`endif

   initial begin
      mclk = 1'b0;
      rst = 1'b1;
      status_start = 1'b0;
      vectors = 0;
      miscompares = 0;
      clear_sources();
      test_reset();
`ifdef SENS_STATUS_ARB_PRIO_EN
      test_prio();
`else
      test_single_source();
      test_all_four();
      test_withdraw();
      test_spurious_start();
      test_reset_mid();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
